// File: rtl/sram_bytemask_clr_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_bytemask_clr_if
// Description : Access bus for sram_bytemask_clr. The master drives the
//               active-low chip/write enables, per-byte mask, address, write
//               data and the clear request; the slave (memory) returns the
//               registered read data, its valid strobe and the busy flag.
// Ports       : chip_enable_i, write_enable_i, byte_mask_i, addr_i, data_i,
//               clear_i (master -> slave); data_o, rvalid_o, busy_o
//               (slave -> master).
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_bytemask_clr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
);
  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;

  logic                  chip_enable_i;
  logic                  write_enable_i;
  logic [NUM_LANES-1:0]  byte_mask_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  clear_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  rvalid_o;
  logic                  busy_o;

  modport master (
    output chip_enable_i, write_enable_i, byte_mask_i, addr_i, data_i, clear_i,
    input  data_o, rvalid_o, busy_o
  );

  modport slave (
    input  chip_enable_i, write_enable_i, byte_mask_i, addr_i, data_i, clear_i,
    output data_o, rvalid_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/sram_bytemask_clr.sv
`default_nettype none
// ============================================================================
// Module      : sram_bytemask_clr
// Description : Register-based single-port synchronous SRAM with per-byte
//               write mask, selectable read-during-write behaviour and a
//               built-in clear engine that zeroes every word after reset or
//               on a clear_i request.
// Ports       : clk_i    - clock, rising edge
//               rst_i    - asynchronous active-high reset
//               bus      - slave side of sram_bytemask_clr_if (enables, mask,
//                          address, write data, clear request, registered
//                          read data, rvalid and busy)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bytemask_clr #(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 7,
  parameter int RDW_MODE       = 0,  // 0: NO_CHANGE, 1: WRITE_FIRST
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sram_bytemask_clr_if.slave bus
);

  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = '1;

  // A word that does not split evenly into mask lanes has no sensible lane map.
  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_width_check
    $fatal(1, "sram_bytemask_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  w_idle;
  logic                  w_rd;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_idle = (state_q == S_IDLE);
  assign w_rd   = w_idle && !bus.chip_enable_i &&  bus.write_enable_i;
  assign w_wr   = w_idle && !bus.chip_enable_i && !bus.write_enable_i;
  assign w_old  = mem_q[bus.addr_i];

  // Merged word: masked lanes from data_i, the rest from the stored word.
  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    assign w_merged[b*BYTE_WIDTH +: BYTE_WIDTH] = bus.byte_mask_i[b]
        ? bus.data_i[b*BYTE_WIDTH +: BYTE_WIDTH]
        : w_old[b*BYTE_WIDTH +: BYTE_WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    rvalid_d = 1'b0;

    if (state_q == S_CLEAR) begin
      // cnt wraps back to 0 naturally after the last word.
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == C_LAST_ADDR) begin
        state_d = S_IDLE;
      end
    end else begin
      if (w_rd) begin
        data_d   = w_old;
        rvalid_d = 1'b1;
      end else if (w_wr && (RDW_MODE == 1)) begin
        data_d   = w_merged;
        rvalid_d = 1'b1;
      end
      // The access above still completes; the clear starts next cycle.
      if (bus.clear_i) begin
        state_d = S_CLEAR;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage carries no reset; writes are blocked while reset is held so the
  // array only changes through the clear engine or a real access.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == S_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (w_wr) begin
        mem_q[bus.addr_i] <= w_merged;
      end
    end
  end

  assign bus.data_o   = data_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.busy_o   = (state_q == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_sram_bytemask_clr.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_bytemask_clr
// Description : Self-checking bench for sram_bytemask_clr. Two instances
//               (NO_CHANGE and WRITE_FIRST) see identical stimulus and are
//               compared every cycle against a word-level reference model,
//               plus a table of directed vectors and multi-cycle sequences
//               for clear length, clear-during-busy and mid-clear reset.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bytemask_clr;

  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_bytemask_clr_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(7)) bus_nc ();
  sram_bytemask_clr_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(7)) bus_wf ();

  sram_bytemask_clr #(.RDW_MODE(0)) u_dut_nc (.clk_i(clk), .rst_i(rst), .bus(bus_nc));
  sram_bytemask_clr #(.RDW_MODE(1)) u_dut_wf (.clk_i(clk), .rst_i(rst), .bus(bus_wf));

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: word array, remaining busy cycles, expected outputs.
  logic [31:0] m_mem [DEPTH];
  int          m_busy;
  logic [31:0] m_q_nc, m_q_wf;
  logic        m_rv_nc, m_rv_wf;

  typedef struct {
    logic        ce;
    logic        we;
    logic [3:0]  mask;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [31:0] q_nc;
    logic        rv_nc;
    logic [31:0] q_wf;
    logic        rv_wf;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ce, input logic we, input logic [3:0] mask,
                       input logic [6:0] addr, input logic [31:0] data, input logic clr);
    bus_nc.chip_enable_i = ce;  bus_wf.chip_enable_i = ce;
    bus_nc.write_enable_i = we; bus_wf.write_enable_i = we;
    bus_nc.byte_mask_i = mask;  bus_wf.byte_mask_i = mask;
    bus_nc.addr_i = addr;       bus_wf.addr_i = addr;
    bus_nc.data_i = data;       bus_wf.data_i = data;
    bus_nc.clear_i = clr;       bus_wf.clear_i = clr;
  endtask

  task automatic model_reset();
    m_busy  = DEPTH;
    m_q_nc  = '0;  m_q_wf  = '0;
    m_rv_nc = 1'b0; m_rv_wf = 1'b0;
  endtask

  task automatic model_check();
    chk("busy_nc",   {31'b0, bus_nc.busy_o},   {31'b0, (m_busy > 0)});
    chk("busy_wf",   {31'b0, bus_wf.busy_o},   {31'b0, (m_busy > 0)});
    chk("data_nc",   bus_nc.data_o,            m_q_nc);
    chk("data_wf",   bus_wf.data_o,            m_q_wf);
    chk("rvalid_nc", {31'b0, bus_nc.rvalid_o}, {31'b0, m_rv_nc});
    chk("rvalid_wf", {31'b0, bus_wf.rvalid_o}, {31'b0, m_rv_wf});
  endtask

  // One clock: inputs applied at negedge, model advanced at posedge,
  // outputs compared at the following negedge.
  task automatic cycle(input logic ce, input logic we, input logic [3:0] mask,
                       input logic [6:0] addr, input logic [31:0] data, input logic clr);
    logic [31:0] word;
    drive(ce, we, mask, addr, data, clr);
    @(posedge clk);
    m_rv_nc = 1'b0;
    m_rv_wf = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      if (!ce) begin
        word = m_mem[addr];
        if (we) begin
          m_q_nc = word; m_q_wf = word;
          m_rv_nc = 1'b1; m_rv_wf = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++)
            if (mask[b]) word[8*b +: 8] = data[8*b +: 8];
          m_mem[addr] = word;
          m_q_wf  = word;
          m_rv_wf = 1'b1;
        end
      end
      if (clr) begin
        m_busy = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end
    @(negedge clk);
    model_check();
  endtask

  task automatic idle();
    cycle(1'b1, 1'b1, 4'h0, 7'd0, 32'd0, 1'b0);
  endtask

  // Counts negedges with busy_o high starting from the current one, until it drops.
  task automatic count_busy(input int first_a, input int first_b, input logic [3:0] dummy,
                            output int cnt_nc, output int cnt_wf);
    cnt_nc = first_a;
    cnt_wf = first_b;
    for (int i = 0; i < 300; i++) begin
      if (!bus_nc.busy_o && !bus_wf.busy_o) break;
      idle();
      if (bus_nc.busy_o) cnt_nc++;
      if (bus_wf.busy_o) cnt_wf++;
    end
  endtask

  initial begin
    int c_nc, c_wf;

    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();
    drive(1'b1, 1'b1, 4'h0, 7'd0, 32'd0, 1'b0);

    // Reset held for 3 cycles.
    repeat (3) @(negedge clk);
    chk("rst_data_nc", bus_nc.data_o, 32'd0);
    chk("rst_rv_wf",   {31'b0, bus_wf.rvalid_o}, 32'd0);
    chk("rst_busy_nc", {31'b0, bus_nc.busy_o},   32'd1);
    rst = 1'b0;

    count_busy(bus_nc.busy_o ? 1 : 0, bus_wf.busy_o ? 1 : 0, 4'h0, c_nc, c_wf);
    chk("init_clear_len_nc", c_nc, DEPTH);
    chk("init_clear_len_wf", c_wf, DEPTH);

    // Reads of first and last word after the clear.
    cycle(1'b0, 1'b1, 4'h0, 7'd0, 32'hFFFF_FFFF, 1'b0);
    chk("rd0_data", bus_nc.data_o, 32'd0);
    chk("rd0_rv",   {31'b0, bus_nc.rvalid_o}, 32'd1);
    idle();
    chk("rv_pulse", {31'b0, bus_nc.rvalid_o}, 32'd0);
    cycle(1'b0, 1'b1, 4'h0, 7'd127, 32'd0, 1'b0);
    chk("rd127_data", bus_wf.data_o, 32'd0);

    // Directed vectors: {ce, we, mask, addr, data, q_nc, rv_nc, q_wf, rv_wf}.
    tbl[0]  = '{1'b1, 1'b0, 4'hF, 7'd0, 32'd42,        32'h0,        1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'hF, 7'd0, 32'd42,        32'h0,        1'b0, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'hF, 7'd0, 32'd42,        32'h0,        1'b0, 32'h2A,       1'b1};
    tbl[3]  = '{1'b0, 1'b1, 4'h0, 7'd0, 32'h0,         32'h2A,       1'b1, 32'h2A,       1'b1};
    tbl[4]  = '{1'b0, 1'b0, 4'hF, 7'd9, 32'hAABBCCDD,  32'h2A,       1'b0, 32'hAABBCCDD, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 4'h5, 7'd9, 32'h11223344,  32'h2A,       1'b0, 32'hAA22CC44, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 4'h0, 7'd9, 32'h0,         32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 7'd9, 32'hFFFFFFFF,  32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 4'h0, 7'd9, 32'h0,         32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 4'h0, 7'd127, 32'h0,       32'h0,        1'b1, 32'h0,        1'b1};
    tbl[10] = '{1'b0, 1'b0, 4'hF, 7'd3, 32'h12345678,  32'h0,        1'b0, 32'h12345678, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'h0, 7'd3, 32'h0,         32'h12345678, 1'b1, 32'h12345678, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 4'h0, 7'd3, 32'h0,         32'h12345678, 1'b0, 32'h12345678, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].ce, tbl[i].we, tbl[i].mask, tbl[i].addr, tbl[i].data, 1'b0);
      chk($sformatf("vec%0d_q_nc", i),  bus_nc.data_o, tbl[i].q_nc);
      chk($sformatf("vec%0d_rv_nc", i), {31'b0, bus_nc.rvalid_o}, {31'b0, tbl[i].rv_nc});
      chk($sformatf("vec%0d_q_wf", i),  bus_wf.data_o, tbl[i].q_wf);
      chk($sformatf("vec%0d_rv_wf", i), {31'b0, bus_wf.rvalid_o}, {31'b0, tbl[i].rv_wf});
    end

    // Clear request with a simultaneous read: the read still completes.
    cycle(1'b0, 1'b1, 4'h0, 7'd9, 32'h0, 1'b1);
    chk("clr_rd_data", bus_nc.data_o, 32'hAA22CC44);
    c_nc = bus_nc.busy_o ? 1 : 0;
    c_wf = bus_wf.busy_o ? 1 : 0;
    // During busy: a write to addr 5 and a second clear request, both ignored.
    for (int i = 0; i < 300; i++) begin
      if (!bus_nc.busy_o && !bus_wf.busy_o) break;
      if (i == 5)       cycle(1'b0, 1'b0, 4'hF, 7'd5, 32'hFF, 1'b0);
      else if (i == 40) cycle(1'b1, 1'b1, 4'h0, 7'd0, 32'h0, 1'b1);
      else              idle();
      if (bus_nc.busy_o) c_nc++;
      if (bus_wf.busy_o) c_wf++;
    end
    chk("req_clear_len_nc", c_nc, DEPTH);
    chk("req_clear_len_wf", c_wf, DEPTH);
    cycle(1'b0, 1'b1, 4'h0, 7'd5, 32'h0, 1'b0);
    chk("rd5_after_clear", bus_nc.data_o, 32'd0);
    cycle(1'b0, 1'b1, 4'h0, 7'd9, 32'h0, 1'b0);
    chk("rd9_after_clear", bus_wf.data_o, 32'd0);

    // Mid-clear asynchronous reset at clear count 60.
    cycle(1'b0, 1'b0, 4'hF, 7'd3, 32'h12345678, 1'b0);
    cycle(1'b0, 1'b1, 4'h0, 7'd3, 32'h0, 1'b1);
    repeat (60) idle();
    chk("pre_rst_data", bus_nc.data_o, 32'h12345678);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data_nc", bus_nc.data_o, 32'd0);
    chk("async_rst_data_wf", bus_wf.data_o, 32'd0);
    chk("async_rst_rv_nc",   {31'b0, bus_nc.rvalid_o}, 32'd0);
    chk("async_rst_busy",    {31'b0, bus_nc.busy_o},   32'd1);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_busy(bus_nc.busy_o ? 1 : 0, bus_wf.busy_o ? 1 : 0, 4'h0, c_nc, c_wf);
    chk("rst_clear_len_nc", c_nc, DEPTH);
    chk("rst_clear_len_wf", c_wf, DEPTH);

    // Randomized traffic on a small address window, with occasional clears.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 1) != 0,
            4'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
            $urandom, ($urandom_range(0, 149) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
